// File: rtl/cont_pkg.sv
// Shared definitions for the time-field counters of the clock/calendar
// setting path: default PS/2 arrow-key codes, the field-position index type
// and the BCD width helper.
package cont_pkg;

   // PS/2 scan codes for keypad 8 (step up) and keypad 2 (step down)
   localparam logic [7:0] KEY_UP_DEF = 8'h75;
   localparam logic [7:0] KEY_DN_DEF = 8'h72;

   // Field-position index as driven by the setting-mode selector
   localparam int POS_W_DEF = 2;
   typedef logic [POS_W_DEF-1:0] pos_t;

   // Packed-BCD width for a given number of decimal digits
   function automatic int bcd_width(input int digits);
      return 4 * digits;
   endfunction

endpackage

// File: rtl/bin_a_bcd.sv
// Combinational binary to packed-BCD converter (double dabble / shift-add-3).
// Digits above the magnitude of the input read 0.
module bin_a_bcd #(
   parameter int W      = 5,
   parameter int DIGITS = 2
) (
   input  logic [W-1:0]        bin,
   output logic [4*DIGITS-1:0] bcd
);

   localparam int SW = 4 * DIGITS + W;

   logic [SW-1:0] sr;

   // Shift the binary value into the BCD field, adding 3 to any digit >= 5
   // before each shift so it carries correctly into the next decade.
   always_comb begin
      // NOTE: every variable gets a full default at the top of always_comb so
      // no path can leave it unassigned and infer a latch.
      sr        = '0;
      sr[W-1:0] = bin;
      for (int i = 0; i < W; i++) begin
         for (int d = 0; d < DIGITS; d++) begin
            if (sr[W+4*d +: 4] > 4'd4)
               sr[W+4*d +: 4] = sr[W+4*d +: 4] + 4'd3;
         end
         sr = sr << 1;
      end
      bcd = sr[SW-1 -: 4*DIGITS];
   end

endmodule

// File: rtl/cont_campo_bcd.sv
// One field (hours, minutes, seconds, day, month...) of the clock/calendar
// setting path. Holds MIN..MAX, steps up/down from PS/2 arrow keys while its
// position is selected, advances from a free-running tick otherwise and
// presents the value in binary and as registered packed BCD.
// Build option: define CONT_CAMPO_CARRY_EN to enable the tick path and
// carry_out; without it the field changes only through load and keys.
module cont_campo_bcd
   import cont_pkg::*;
#(
   parameter int         N      = 8,
   parameter int         P      = 2,
   parameter int         MY_POS = 0,
   parameter int         MIN    = 0,
   parameter int         MAX    = 23,
   parameter int         DIGITS = 2,
   parameter int         W      = $clog2(MAX + 1),
   parameter logic [N-1:0] KEY_UP = N'(KEY_UP_DEF),
   parameter logic [N-1:0] KEY_DN = N'(KEY_DN_DEF)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [P-1:0]                   posicion,
   input  logic                           edit_en,
   input  logic                           en_codigo,
   input  logic [N-1:0]                   key_code,
   input  logic                           tick,
   input  logic                           load,
   input  logic [W-1:0]                   load_val,
   output logic [W-1:0]                   valor,
   output logic [bcd_width(DIGITS)-1:0]   dato_bcd,
   output logic                           carry_out,
   output logic                           key_ack,
   output logic                           editando
);

   localparam logic [W-1:0] MIN_V = W'(MIN);
   localparam logic [W-1:0] MAX_V = W'(MAX);
   localparam logic [W-1:0] ONE_V = W'(1);

   logic         en_codigo_q;
   logic         selected;
   logic         key_ev;
   logic         tick_ok;
   logic         below_min;
   logic         above_max;
   logic         at_min;
   logic         at_max;
   logic [W-1:0] bcd_src;
   logic [bcd_width(DIGITS)-1:0] bcd_comb;

   assign selected = edit_en && (posicion == P'(MY_POS));
   assign key_ev   = en_codigo && !en_codigo_q;
   assign at_min   = (valor == MIN_V);
   assign at_max   = (valor == MAX_V);

`ifdef CONT_CAMPO_CARRY_EN
   // Ticks only advance the field while it is not being set
   assign tick_ok = tick && !selected;
`else
   logic unused_tick;
   assign unused_tick = tick;
   assign tick_ok     = 1'b0;
`endif

   // Range limits that cannot be violated by a W-bit value are folded away
   // so the comparison is never a constant.
   if (MIN == 0) begin : g_no_lo
      assign below_min = 1'b0;
   end else begin : g_lo
      assign below_min = (load_val < MIN_V);
   end

   if (MAX == (2 ** W) - 1) begin : g_no_hi
      assign above_max = 1'b0;
   end else begin : g_hi
      assign above_max = (load_val > MAX_V);
   end

   // Convert MIN during reset so dato_bcd comes out of reset as BCD(MIN)
   assign bcd_src = rst ? MIN_V : valor;

   bin_a_bcd #(
      .W      (W),
      .DIGITS (DIGITS)
   ) u_bin_a_bcd (
      .bin (bcd_src),
      .bcd (bcd_comb)
   );

   // Field value and pulse outputs: rst > load > key step > tick
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (rst) begin
         valor       <= MIN_V;
         en_codigo_q <= 1'b0;
         carry_out   <= 1'b0;
         key_ack     <= 1'b0;
         editando    <= 1'b0;
      end else begin
         en_codigo_q <= en_codigo;
         editando    <= selected;
         carry_out   <= 1'b0;
         key_ack     <= 1'b0;
         if (load) begin
            valor <= (below_min || above_max) ? MIN_V : load_val;
         end else if (selected && key_ev) begin
            if (key_code == KEY_UP) begin
               valor   <= at_max ? MIN_V : valor + ONE_V;
               key_ack <= 1'b1;
            end else if (key_code == KEY_DN) begin
               valor   <= at_min ? MAX_V : valor - ONE_V;
               key_ack <= 1'b1;
            end
         end else if (tick_ok) begin
            valor     <= at_max ? MIN_V : valor + ONE_V;
            carry_out <= at_max;
         end
      end
   end

   // Registered BCD view, one cycle behind valor
   always_ff @(posedge clk) begin
      dato_bcd <= bcd_comb;
   end

endmodule

// File: tb/tb_cont_campo_bcd.sv
// Directed bench for cont_campo_bcd: an hours field (0..23) and a month-like
// field (1..12), both at position 0. Expectations for the tick path follow
// the CONT_CAMPO_CARRY_EN build option.
module tb_cont_campo_bcd;
   import cont_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   pos_t       posicion;
   logic       edit_en;
   logic       en_codigo;
   logic [7:0] key_code;
   logic       tick;
   logic       load;
   logic [4:0] load_val;
   logic [4:0] valor;
   logic [7:0] dato_bcd;
   logic       carry_out;
   logic       key_ack;
   logic       editando;

   logic       edit_en1;
   logic       en_codigo1;
   logic [7:0] key_code1;
   logic       tick1;
   logic       load1;
   logic [3:0] load_val1;
   logic [3:0] valor1;
   logic [7:0] dato_bcd1;
   logic       carry_out1;
   logic       key_ack1;
   logic       editando1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cont_campo_bcd #(.MIN(0), .MAX(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .posicion  (posicion),
      .edit_en   (edit_en),
      .en_codigo (en_codigo),
      .key_code  (key_code),
      .tick      (tick),
      .load      (load),
      .load_val  (load_val),
      .valor     (valor),
      .dato_bcd  (dato_bcd),
      .carry_out (carry_out),
      .key_ack   (key_ack),
      .editando  (editando)
   );

   cont_campo_bcd #(.MIN(1), .MAX(12)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .posicion  (posicion),
      .edit_en   (edit_en1),
      .en_codigo (en_codigo1),
      .key_code  (key_code1),
      .tick      (tick1),
      .load      (load1),
      .load_val  (load_val1),
      .valor     (valor1),
      .dato_bcd  (dato_bcd1),
      .carry_out (carry_out1),
      .key_ack   (key_ack1),
      .editando  (editando1)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock and settle just past the edge
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load_value(input logic [4:0] v);
      load     = 1'b1;
      load_val = v;
      step();
      load     = 1'b0;
   endtask

   initial begin
      rst = 1'b1; posicion = '0; edit_en = 1'b0; en_codigo = 1'b0;
      key_code = 8'h00; tick = 1'b0; load = 1'b0; load_val = '0;
      edit_en1 = 1'b0; en_codigo1 = 1'b0; key_code1 = 8'h00;
      tick1 = 1'b0; load1 = 1'b0; load_val1 = '0;
      step(2);

      // Reset state
      check("rst_valor", valor, 0);
      check("rst_bcd", dato_bcd, 8'h00);
      check("rst_carry", carry_out, 0);
      check("rst_ack", key_ack, 0);
      check("rst_edit", editando, 0);
      check("rst_valor1", valor1, 1);
      check("rst_bcd1", dato_bcd1, 8'h01);
      rst = 1'b0;
      step();

      // Preset to 23
      load_value(5'd23);
      check("load23", valor, 23);
      step();
      check("load23_bcd", dato_bcd, 8'h23);

      // KEY_UP held 5 cycles at 23: exactly one wrap to 0
      edit_en = 1'b1; key_code = 8'h75; en_codigo = 1'b1;
      step();
      check("up_wrap", valor, 0);
      check("up_ack", key_ack, 1);
      check("up_nocarry", carry_out, 0);
      check("up_edit", editando, 1);
      step();
      check("up_ack_1cyc", key_ack, 0);
      check("up_bcd", dato_bcd, 8'h00);
      step(3);
      check("up_held_once", valor, 0);
      en_codigo = 1'b0;
      step();

      // KEY_DN at 0 wraps to 23
      key_code = 8'h72; en_codigo = 1'b1;
      step();
      check("dn_wrap", valor, 23);
      check("dn_ack", key_ack, 1);
      en_codigo = 1'b0;
      step();
      check("dn_bcd", dato_bcd, 8'h23);

      // Unrecognised code
      key_code = 8'h6B; en_codigo = 1'b1;
      step();
      check("other_valor", valor, 23);
      check("other_ack", key_ack, 0);
      en_codigo = 1'b0;
      step();

      // Tick while selected is dropped
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("tick_sel_valor", valor, 23);
      check("tick_sel_carry", carry_out, 0);

      // Tick while not selected
      edit_en = 1'b0;
      tick = 1'b1;
      step();
      tick = 1'b0;
`ifdef CONT_CAMPO_CARRY_EN
      check("tick_wrap", valor, 0);
      check("tick_carry", carry_out, 1);
`else
      check("tick_off_valor", valor, 23);
      check("tick_off_carry", carry_out, 0);
`endif
      check("tick_edit", editando, 0);
      step();
      check("carry_1cyc", carry_out, 0);

      // Key while not selected is ignored; a still-high code after selecting
      // gives no event because the previous sample was already high
      load_value(5'd10);
      key_code = 8'h75; en_codigo = 1'b1;
      step();
      check("unsel_key", valor, 10);
      edit_en = 1'b1;
      step();
      check("held_no_ev", valor, 10);
      check("held_no_ack", key_ack, 0);
      en_codigo = 1'b0;
      edit_en = 1'b0;
      step();

      // Out-of-range preset falls back to MIN, in-range preset is taken
      load_value(5'd30);
      check("load30", valor, 0);
      load_value(5'd17);
      check("load17", valor, 17);
      step();
      check("load17_bcd", dato_bcd, 8'h17);

      // Load and key event in the same cycle: load wins, no ack
      edit_en = 1'b1; key_code = 8'h75; en_codigo = 1'b1;
      load_value(5'd5);
      check("load_vs_key", valor, 5);
      check("load_vs_key_ack", key_ack, 0);
      en_codigo = 1'b0; edit_en = 1'b0;
      step();

      // Reset mid-sequence wins over a load on the same edge
      rst = 1'b1; load = 1'b1; load_val = 5'd9;
      step();
      check("rst_wins", valor, 0);
      rst = 1'b0; load = 1'b0;
      step();

      // MIN=1/MAX=12: KEY_DN at 1 wraps to 12
      edit_en1 = 1'b1; key_code1 = 8'h72; en_codigo1 = 1'b1;
      step();
      check("m_dn_wrap", valor1, 12);
      check("m_dn_ack", key_ack1, 1);
      en_codigo1 = 1'b0;
      step();
      check("m_dn_bcd", dato_bcd1, 8'h12);

      // Ten ticks from 12 with the field unselected
      edit_en1 = 1'b0;
      tick1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
`ifdef CONT_CAMPO_CARRY_EN
         check("m_tick_carry", carry_out1, (i == 0) ? 1 : 0);
`else
         check("m_tick_carry", carry_out1, 0);
`endif
      end
      tick1 = 1'b0;
`ifdef CONT_CAMPO_CARRY_EN
      check("m_tick_valor", valor1, 10);
`else
      check("m_tick_valor", valor1, 12);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
